fmap_reader: RTL and testbench
==============================

Name: fmap_reader

Overview:
- Read-side counterpart to the convolution engine's BRAM write port.
- Once one convolution pass has finished, this block reads the 32-bit accumulator feature map back out of the result BRAM in raster order.
- Each word is requantized (bias add, optional ReLU, arithmetic right shift, saturate to int8).
- Results stream out as 8-bit pixels with a valid/ready handshake, suitable for the streaming pixel input of the next conv layer.

Parameters:
- MAPSIZE, 32, input map size of the producing conv layer; feature map holds (MAPSIZE-4)^2 words.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin reading one full feature map (sampled in IDLE only)
- bias  in  32 signed  added to every accumulator; held stable from start until all_done
- shift  in  5  arithmetic right-shift amount, 0..31; held stable
- relu_en  in  1  clamp negative sums to 0 before shifting; held stable
- mem_rd_en  out  1  BRAM read enable
- mem_rd_addr  out  $clog2((MAPSIZE-4)^2)  BRAM read address
- mem_rd_data  in  32 signed  BRAM data, valid exactly 1 cycle after mem_rd_en
- pixel_out  out  8 signed  requantized pixel
- pixel_valid  out  1  pixel_out valid
- pixel_ready  in  1  downstream accept; transfer occurs when valid && ready
- busy  out  1  high in READ and DRAIN
- all_done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset: all outputs 0; state IDLE; read address, output count, in-flight count and FIFO pointers cleared.
- Reset mid-operation:
  - Aborts immediately.
  - FIFO contents and in-flight reads are discarded.
  - No pixel_valid in the cycle after the reset.
- States IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On start, clear counters and go to READ.
  - start asserted in any other state is ignored.
- READ:
  - Assert mem_rd_en with mem_rd_addr = rd_ctr when (fifo_count + inflight) < FIFO_DEPTH.
  - inflight counts reads issued but not yet written to the FIFO; maximum 2.
  - rd_ctr increments on every issued read.
  - After issuing address (MAPSIZE-4)^2-1, go to DRAIN.
  - mem_rd_en is never asserted outside READ.
- Pipeline, per read issued in cycle t:
  - mem_rd_data is sampled at t+1.
  - The requantized value is registered and written to the FIFO at the end of t+1.
  - It is visible on pixel_out/pixel_valid from cycle t+2 if the FIFO was empty.
  - Start sampled in cycle 0 gives first mem_rd_en in cycle 1 and first pixel_valid in cycle 3.
- Requantize, evaluated in 33-bit signed arithmetic (no wrap):
  - s = mem_rd_data + bias.
  - If relu_en and s < 0, then s = 0.
  - q = s >>> shift.
  - pixel = q > 127 ? 127 : q < -128 ? -128 : q[7:0].
- Handshake:
  - pixel_out and pixel_valid change only after a transfer or a FIFO write into an empty FIFO.
  - While valid && !ready, pixel_out is held stable.
  - The FIFO never overflows (guaranteed by the credit check). A simultaneous FIFO push and pop leaves the count unchanged.
- DRAIN:
  - Wait until inflight == 0, FIFO empty, and out_ctr == (MAPSIZE-4)^2.
  - out_ctr counts transfers; it is not cleared on DRAIN exit.
  - Then go to DONE.
- DONE: all_done = 1 for one cycle; busy = 0; return to IDLE. A start in the DONE cycle is ignored.
- Throughput: with pixel_ready held high, one pixel per cycle after the initial latency. Total run is (MAPSIZE-4)^2 + 4 cycles from start to the all_done pulse.

Decomposition:
- Shared package conv_pkg:
  - fmap_state_t enum (IDLE, READ, DRAIN, DONE).
  - Function fmap_words(mapsize) returning (mapsize-4)^2.
  - Function requant8(acc, bias, shift, relu) used by this block and by the testbench reference model.
- One sub-module: sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH), providing count, full, empty and registered first-word output.

Test Plan:
- MAPSIZE=8 (16 words), BRAM preloaded mem[i]=i*256, bias=0, shift=8, relu_en=0, ready=1 -> pixels 0..15 in order, one per cycle; mem_rd_en first in cycle 1; pixel_valid first in cycle 3; all_done in cycle 20.
- Saturation and rounding:
  - Words 100000, -100000 and -1 with bias=0 and shift=4 give 127, -128 and -1 (arithmetic shift floors).
  - With shift=0, word 127 gives 127 and word 128 gives 127.
- ReLU: relu_en=1, bias=-50, words 40, 50, 60 with shift=0 -> outputs 0, 0, 10.
- Backpressure:
  - Hold pixel_ready=0 for cycles 3..12.
  - Required: pixel_out stays at pixel 0 and is unchanged throughout.
  - Required: mem_rd_en stops after FIFO_DEPTH outstanding reads.
  - Required: releasing ready delivers all 16 pixels with no loss or duplication, in order.
  - Random ready at 50% -> output sequence matches the reference model.
- Reset mid-run: assert rst after 5 transfers -> the next cycle shows pixel_valid=0, busy=0, mem_rd_en=0; a new start reads from address 0.
- start pulsed during READ and during DONE -> ignored; exactly one all_done per accepted start.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: reader FSM states, feature-map
// sizing and the int8 requantization applied to 32-bit accumulators.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fmap_state_t;

    localparam int ACC_W = 32;
    localparam int PIX_W = 8;

    // Number of accumulator words produced by one pass over a mapsize x mapsize input
    // with a 5x5 valid convolution.
    function automatic int fmap_words(input int mapsize);
        return (mapsize - 4) * (mapsize - 4);
    endfunction

    // Bias add, optional ReLU, arithmetic right shift, saturate to int8.
    // Everything is done in 33 bits so that acc + bias can never wrap.
    function automatic logic signed [PIX_W-1:0] requant8(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W-1:0] bias,
        input logic        [4:0]       shift,
        input logic                    relu
    );
        logic signed [ACC_W:0] s;
        logic signed [ACC_W:0] q;
        s = $signed({acc[ACC_W-1], acc}) + $signed({bias[ACC_W-1], bias});
        if (relu && s[ACC_W]) begin
            s = '0;
        end
        q = s >>> shift;
        if (q > 33'sd127) begin
            return 8'sd127;
        end else if (q < -33'sd128) begin
            return -8'sd128;
        end else begin
            return q[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head word: dout always shows the oldest
// entry (0 when empty) straight from a flop, so downstream sees a clean output.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] kept;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] head_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign dout    = dout_q;

    // Next pointer/count and the word that will sit at the head next cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        kept     = count_q;
        head_d   = dout_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            kept     = count_q - CNT_W'(1);
        end
        count_d = kept + CNT_W'(do_push);
        if (count_d == '0) begin
            head_d = '0;
        end else if (kept == '0) begin
            // Nothing older survives this cycle, so the word being pushed becomes the head.
            head_d = din;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; empty/count gate its contents, and leaving it out keeps it mappable to LUT RAM.
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy and registered head word.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= head_d;
        end
    end

endmodule

// File: rtl/fmap_reader.sv
// Reads one finished accumulator feature map out of the result BRAM in raster order,
// requantizes each word to int8 and streams the pixels out over valid/ready.
// Reads are only issued when the output FIFO has room for them (credit check), so
// backpressure simply pauses the BRAM reads and nothing is ever dropped.
module fmap_reader
    import conv_pkg::*;
#(
    parameter int MAPSIZE    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic signed [31:0]                                bias,
    input  logic        [4:0]                                 shift,
    input  logic                                              relu_en,
    output logic                                              mem_rd_en,
    output logic        [$clog2((MAPSIZE-4)*(MAPSIZE-4))-1:0] mem_rd_addr,
    input  logic signed [31:0]                                mem_rd_data,
    output logic signed [7:0]                                 pixel_out,
    output logic                                              pixel_valid,
    input  logic                                              pixel_ready,
    output logic                                              busy,
    output logic                                              all_done
);

    localparam int WORDS  = fmap_words(MAPSIZE);
    localparam int ADDR_W = $clog2(WORDS);
    localparam int OUT_W  = $clog2(WORDS + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    localparam logic [OUT_W-1:0]  OUT_TOTAL = OUT_W'(WORDS);

    fmap_state_t state_q;
    fmap_state_t state_d;

    logic [ADDR_W-1:0] rd_ctr_q;     // next address to read
    logic [OUT_W-1:0]  out_ctr_q;    // pixels transferred downstream
    logic [1:0]        inflight_q;   // reads issued but not yet pushed into the FIFO
    logic              rd_pend_q;    // a read was issued last cycle: its data is on mem_rd_data now

    logic              start_accept;
    logic              credit_ok;
    logic              issue;
    logic              xfer;

    logic              fifo_push;
    logic [7:0]        fifo_din;
    logic [7:0]        fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // Reads in flight already own a FIFO slot, so they count against the free space.
    assign credit_ok    = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
    assign start_accept = (state_q == IDLE) && start;
    assign issue        = (state_q == READ) && credit_ok;
    assign xfer         = pixel_valid && pixel_ready;

    // The BRAM answers one cycle after the read; requantize that word and push it.
    assign fifo_push = rd_pend_q;
    assign fifo_din  = requant8(mem_rd_data, bias, shift, relu_en);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (xfer),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pixel_out   = $signed(fifo_dout);
    assign pixel_valid = !fifo_empty;
    assign mem_rd_addr = rd_ctr_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (issue && (rd_ctr_q == LAST_ADDR)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((inflight_q == 2'd0) && fifo_empty && (out_ctr_q == OUT_TOTAL)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        mem_rd_en = 1'b0;
        busy      = 1'b0;
        all_done  = 1'b0;
        unique case (state_q)
            READ: begin
                mem_rd_en = credit_ok;
                busy      = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            DONE: begin
                all_done = 1'b1;
            end
            default: begin
                mem_rd_en = 1'b0;
            end
        endcase
    end

    // Read address, transfer count and read-pipeline tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ctr_q   <= '0;
            out_ctr_q  <= '0;
            inflight_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            if (start_accept) begin
                rd_ctr_q <= '0;
            end else if (issue) begin
                rd_ctr_q <= rd_ctr_q + ADDR_W'(1);
            end

            if (start_accept) begin
                out_ctr_q <= '0;
            end else if (xfer) begin
                out_ctr_q <= out_ctr_q + OUT_W'(1);
            end

            inflight_q <= inflight_q + 2'(issue) - 2'(rd_pend_q);
            rd_pend_q  <= issue;
        end
    end

endmodule

// File: tb/tb_fmap_reader.sv
// Directed bench for fmap_reader with a 16-word map (MAPSIZE=8) and a behavioural
// BRAM whose read data appears one cycle after mem_rd_en.
module tb_fmap_reader;

    localparam int MAPSIZE    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int WORDS      = 16;
    localparam int AW         = 4;
    localparam int MAX_CYC    = 400;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] bias;
    logic        [4:0]  shift;
    logic               relu_en;
    logic               mem_rd_en;
    logic      [AW-1:0] mem_rd_addr;
    logic signed [31:0] mem_rd_data;
    logic signed [7:0]  pixel_out;
    logic               pixel_valid;
    logic               pixel_ready;
    logic               busy;
    logic               all_done;

    logic signed [31:0] bram [WORDS];
    logic signed [7:0]  pixq [$];
    logic signed [7:0]  expv [WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    fmap_reader #(
        .MAPSIZE    (MAPSIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bias        (bias),
        .shift       (shift),
        .relu_en     (relu_en),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= bram[mem_rd_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < WORDS; i++) begin
            bram[i] = i * 256;
            expv[i] = 8'(i);
        end
    endtask

    // Runs one map. mode 0: ready always high; 1: ready low in cycles 3..12; 2: random ready.
    // spulse: cycle in which an extra start pulse is driven (-1 for none).
    // Returns at the cycle where all_done is seen (before its closing edge) or on timeout.
    task automatic run_map(input int mode, input int spulse,
                           output int en_first, output int first_addr, output int valid_first,
                           output int done_cyc, output int n_done, output int reads_hold,
                           output int hold_bad, output int held_val);
        en_first = -1; first_addr = -1; valid_first = -1; done_cyc = -1;
        n_done = 0; reads_hold = 0; hold_bad = 0; held_val = -999;
        pixq.delete();
        pixel_ready = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < MAX_CYC; c++) begin
            start = (c == spulse);
            case (mode)
                1:       pixel_ready = !(c >= 3 && c <= 12);
                2:       pixel_ready = 1'($urandom_range(0, 1));
                default: pixel_ready = 1'b1;
            endcase
            if (mem_rd_en && en_first < 0) begin
                en_first   = c;
                first_addr = int'(mem_rd_addr);
            end
            if (mem_rd_en && c <= 12) reads_hold++;
            if (pixel_valid && valid_first < 0) valid_first = c;
            if (c == 3) held_val = int'(pixel_out);
            if (c >= 3 && c <= 12 && (!pixel_valid || int'(pixel_out) != held_val)) hold_bad++;
            if (pixel_valid && pixel_ready) pixq.push_back(pixel_out);
            if (all_done) begin
                n_done++;
                done_cyc = c;
                break;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        n_checks++; if (mem_rd_addr !== '0) $display("FAIL reset_rd_addr: got %0d want 0", mem_rd_addr); else n_pass++;
        n_checks++; if (pixel_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", pixel_valid); else n_pass++;
        n_checks++; if (pixel_out !== 8'sd0) $display("FAIL reset_pixel: got %0d want 0", pixel_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (all_done !== 1'b0) $display("FAIL reset_done: got %b want 0", all_done); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        int ef, fa, vf, dc, nd, rh, hb, hv;
        load_ramp();
        bias = 0; shift = 5'd8; relu_en = 1'b0;
        run_map(0, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        n_checks++; if (ef !== 1) $display("FAIL ramp_first_rd_en_cycle: got %0d want 1", ef); else n_pass++;
        n_checks++; if (fa !== 0) $display("FAIL ramp_first_addr: got %0d want 0", fa); else n_pass++;
        n_checks++; if (vf !== 3) $display("FAIL ramp_first_valid_cycle: got %0d want 3", vf); else n_pass++;
        n_checks++; if (dc !== 20) $display("FAIL ramp_done_cycle: got %0d want 20", dc); else n_pass++;
        n_checks++; if (pixq.size() != WORDS) $display("FAIL ramp_count: got %0d want %0d", pixq.size(), WORDS); else n_pass++;
        for (int i = 0; i < WORDS && i < pixq.size(); i++) begin
            n_checks++; if (pixq[i] !== expv[i]) $display("FAIL ramp_pixel[%0d]: got %0d want %0d", i, pixq[i], expv[i]); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int ef, fa, vf, dc, nd, rh, hb, hv;
        // shift=4: large positive, large negative, and -1 (floors, stays -1)
        for (int i = 0; i < WORDS; i++) bram[i] = 0;
        bram[0] = 100000; bram[1] = -100000; bram[2] = -1;
        bias = 0; shift = 5'd4; relu_en = 1'b0;
        run_map(0, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        n_checks++; if (pixq.size() != WORDS) $display("FAIL sat4_count: got %0d want %0d", pixq.size(), WORDS); else n_pass++;
        if (pixq.size() >= 3) begin
            n_checks++; if (pixq[0] !== 8'sd127) $display("FAIL sat4_pos: got %0d want 127", pixq[0]); else n_pass++;
            n_checks++; if (pixq[1] !== -8'sd128) $display("FAIL sat4_neg: got %0d want -128", pixq[1]); else n_pass++;
            n_checks++; if (pixq[2] !== -8'sd1) $display("FAIL sat4_minus1: got %0d want -1", pixq[2]); else n_pass++;
        end
        // shift=0: the int8 edge
        bram[0] = 127; bram[1] = 128; bram[2] = -128; bram[3] = -129;
        shift = 5'd0;
        run_map(0, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        if (pixq.size() >= 4) begin
            n_checks++; if (pixq[0] !== 8'sd127) $display("FAIL sat0_127: got %0d want 127", pixq[0]); else n_pass++;
            n_checks++; if (pixq[1] !== 8'sd127) $display("FAIL sat0_128: got %0d want 127", pixq[1]); else n_pass++;
            n_checks++; if (pixq[2] !== -8'sd128) $display("FAIL sat0_m128: got %0d want -128", pixq[2]); else n_pass++;
            n_checks++; if (pixq[3] !== -8'sd128) $display("FAIL sat0_m129: got %0d want -128", pixq[3]); else n_pass++;
        end else begin
            n_checks++; $display("FAIL sat0_count: got %0d want %0d", pixq.size(), WORDS);
        end
        // 33-bit sum: 0x7FFFFFFF + 0x7FFFFFFF = 2^32-2, >>>31 = 1 (a 32-bit wrap would give -1)
        for (int i = 0; i < WORDS; i++) bram[i] = 0;
        bram[0] = 32'sh7FFF_FFFF;
        bias = 32'sh7FFF_FFFF; shift = 5'd31;
        run_map(0, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        if (pixq.size() >= 2) begin
            n_checks++; if (pixq[0] !== 8'sd1) $display("FAIL wide_sum: got %0d want 1", pixq[0]); else n_pass++;
            n_checks++; if (pixq[1] !== 8'sd0) $display("FAIL wide_bias_only: got %0d want 0", pixq[1]); else n_pass++;
        end else begin
            n_checks++; $display("FAIL wide_count: got %0d want %0d", pixq.size(), WORDS);
        end
        bias = 0;
    endtask

    task automatic test_relu();
        int ef, fa, vf, dc, nd, rh, hb, hv;
        for (int i = 0; i < WORDS; i++) bram[i] = 0;
        bram[0] = 40; bram[1] = 50; bram[2] = 60; bram[3] = 300;
        bias = -50; shift = 5'd0; relu_en = 1'b1;
        run_map(0, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        if (pixq.size() >= 5) begin
            n_checks++; if (pixq[0] !== 8'sd0) $display("FAIL relu_40: got %0d want 0", pixq[0]); else n_pass++;
            n_checks++; if (pixq[1] !== 8'sd0) $display("FAIL relu_50: got %0d want 0", pixq[1]); else n_pass++;
            n_checks++; if (pixq[2] !== 8'sd10) $display("FAIL relu_60: got %0d want 10", pixq[2]); else n_pass++;
            n_checks++; if (pixq[3] !== 8'sd127) $display("FAIL relu_300: got %0d want 127", pixq[3]); else n_pass++;
            n_checks++; if (pixq[4] !== 8'sd0) $display("FAIL relu_0: got %0d want 0", pixq[4]); else n_pass++;
        end else begin
            n_checks++; $display("FAIL relu_count: got %0d want %0d", pixq.size(), WORDS);
        end
        bias = 0; relu_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int ef, fa, vf, dc, nd, rh, hb, hv;
        load_ramp();
        bias = 0; shift = 5'd8; relu_en = 1'b0;
        run_map(1, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        n_checks++; if (hv !== 0) $display("FAIL bp_held_value: got %0d want 0", hv); else n_pass++;
        n_checks++; if (hb !== 0) $display("FAIL bp_hold_changes: got %0d want 0", hb); else n_pass++;
        n_checks++; if (rh !== FIFO_DEPTH) $display("FAIL bp_reads_while_stalled: got %0d want %0d", rh, FIFO_DEPTH); else n_pass++;
        n_checks++; if (nd !== 1) $display("FAIL bp_done: got %0d want 1", nd); else n_pass++;
        n_checks++; if (pixq.size() != WORDS) $display("FAIL bp_count: got %0d want %0d", pixq.size(), WORDS); else n_pass++;
        for (int i = 0; i < WORDS && i < pixq.size(); i++) begin
            n_checks++; if (pixq[i] !== expv[i]) $display("FAIL bp_pixel[%0d]: got %0d want %0d", i, pixq[i], expv[i]); else n_pass++;
        end
    endtask

    task automatic test_random_ready();
        int ef, fa, vf, dc, nd, rh, hb, hv;
        load_ramp();
        run_map(2, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        n_checks++; if (nd !== 1) $display("FAIL rnd_done: got %0d want 1", nd); else n_pass++;
        n_checks++; if (pixq.size() != WORDS) $display("FAIL rnd_count: got %0d want %0d", pixq.size(), WORDS); else n_pass++;
        for (int i = 0; i < WORDS && i < pixq.size(); i++) begin
            n_checks++; if (pixq[i] !== expv[i]) $display("FAIL rnd_pixel[%0d]: got %0d want %0d", i, pixq[i], expv[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        int ef, fa, vf, dc, nd, rh, hb, hv;
        int xfers;
        load_ramp();
        pixel_ready = 1'b1;
        xfers = 0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 60; c++) begin
            if (pixel_valid && pixel_ready) xfers++;
            if (xfers == 5) break;
            step();
        end
        n_checks++; if (xfers !== 5) $display("FAIL rstmid_transfers: got %0d want 5", xfers); else n_pass++;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (pixel_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", pixel_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        run_map(0, -1, ef, fa, vf, dc, nd, rh, hb, hv);
        n_checks++; if (fa !== 0) $display("FAIL rstmid_restart_addr: got %0d want 0", fa); else n_pass++;
        n_checks++; if (dc !== 20) $display("FAIL rstmid_done_cycle: got %0d want 20", dc); else n_pass++;
        n_checks++; if (pixq.size() != WORDS) $display("FAIL rstmid_count: got %0d want %0d", pixq.size(), WORDS); else n_pass++;
        for (int i = 0; i < WORDS && i < pixq.size(); i++) begin
            n_checks++; if (pixq[i] !== expv[i]) $display("FAIL rstmid_pixel[%0d]: got %0d want %0d", i, pixq[i], expv[i]); else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int ef, fa, vf, dc, nd, rh, hb, hv;
        int stray;
        load_ramp();
        run_map(0, 6, ef, fa, vf, dc, nd, rh, hb, hv);
        n_checks++; if (nd !== 1) $display("FAIL sig_done_count: got %0d want 1", nd); else n_pass++;
        n_checks++; if (dc !== 20) $display("FAIL sig_done_cycle: got %0d want 20", dc); else n_pass++;
        n_checks++; if (pixq.size() != WORDS) $display("FAIL sig_count: got %0d want %0d", pixq.size(), WORDS); else n_pass++;
        for (int i = 0; i < WORDS && i < pixq.size(); i++) begin
            n_checks++; if (pixq[i] !== expv[i]) $display("FAIL sig_pixel[%0d]: got %0d want %0d", i, pixq[i], expv[i]); else n_pass++;
        end
        // Currently in the DONE cycle: a start here must not launch another run.
        start = 1'b1;
        step();
        start = 1'b0;
        stray = 0;
        for (int c = 0; c < 30; c++) begin
            if (busy || mem_rd_en || all_done || pixel_valid) stray++;
            step();
        end
        n_checks++; if (stray !== 0) $display("FAIL sig_start_in_done: got %0d active cycles want 0", stray); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pixel_ready = 1'b1;
        bias = 0; shift = 5'd0; relu_en = 1'b0;
        for (int i = 0; i < WORDS; i++) bram[i] = 0;
        test_reset();
        test_ramp();
        test_saturation();
        test_relu();
        test_backpressure();
        test_random_ready();
        test_reset_mid_run();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
